// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer
//   Sequences the HPS ROM download into the arcade core and owns the core's
//   reset. The ioctl write stream is registered onto the core's dn_* port,
//   the image is checked for strictly sequential addressing and exact size,
//   and the core is held in reset until a good image is loaded. After every
//   good load or soft reset the core stays in reset for HOLD_CYCLES cycles.
//
// Ports
//   clk_sys, reset_n          system clock, async active-low reset
//   ioctl_download/wr/addr/dout  download stream from hps_io
//   soft_reset                level reset request from the menu/buttons
//   dn_addr/dn_data/dn_wr     registered write port into the core
//   core_reset                active-high reset to the core
//   rom_valid, load_error     result of the last completed load
//   byte_count                writes accepted in the current/last load
module rom_load_sequencer #(
    parameter int TOTAL_BYTES = 49152,
    parameter int HOLD_CYCLES = 1024
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        soft_reset,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic        core_reset,
    output logic        rom_valid,
    output logic        load_error,
    output logic [16:0] byte_count
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_RUN   = 3'd4;

    localparam logic [24:0]   TOTAL     = 25'(TOTAL_BYTES);
    localparam logic [16:0]   CNT_MAX   = '1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    logic [2:0]    state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [16:0]   exp_addr_q, exp_addr_d;
    logic [16:0]   byte_count_q, byte_count_d;
    logic          err_q, err_d;
    logic          rom_valid_q, rom_valid_d;
    logic          load_error_q, load_error_d;
    logic [15:0]   dn_addr_q, dn_addr_d;
    logic [7:0]    dn_data_q, dn_data_d;
    logic          dn_wr_q, dn_wr_d;
    logic          dl_q, sr_q;

    logic dl_rise, dl_fall, sr_rise, wr_in_range, wr_in_seq;

    // Edges compare the live input against last cycle's sample, so the
    // state change lands on the cycle right after the input transition.
    assign dl_rise = ioctl_download & ~dl_q;
    assign dl_fall = ~ioctl_download & dl_q;
    assign sr_rise = soft_reset & ~sr_q;

    assign wr_in_range = (ioctl_addr < TOTAL);
    assign wr_in_seq   = (ioctl_addr == {8'd0, exp_addr_q});

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        exp_addr_d   = exp_addr_q;
        byte_count_d = byte_count_q;
        err_d        = err_q;
        rom_valid_d  = rom_valid_q;
        load_error_d = load_error_q;
        dn_addr_d    = dn_addr_q;
        dn_data_d    = dn_data_q;
        dn_wr_d      = 1'b0;

        if (dl_rise) begin
            // A new download overrides whatever the sequencer was doing.
            state_d      = S_LOAD;
            exp_addr_d   = '0;
            byte_count_d = '0;
            err_d        = 1'b0;
            rom_valid_d  = 1'b0;
            load_error_d = 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (dl_fall) begin
                        // Write in the falling cycle is dropped on purpose.
                        state_d = S_CHECK;
                    end else if (ioctl_wr && ioctl_download) begin
                        if (wr_in_range && wr_in_seq) begin
                            dn_wr_d   = 1'b1;
                            dn_addr_d = ioctl_addr[15:0];
                            dn_data_d = ioctl_dout;
                            if (exp_addr_q != CNT_MAX)   exp_addr_d   = exp_addr_q + 17'd1;
                            if (byte_count_q != CNT_MAX) byte_count_d = byte_count_q + 17'd1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    if (({8'd0, byte_count_q} == TOTAL) && !err_q) begin
                        rom_valid_d = 1'b1;
                        state_d     = S_HOLD;
                        hold_cnt_d  = HOLD_LOAD;
                    end else begin
                        load_error_d = 1'b1;
                        state_d      = S_IDLE;
                    end
                end
                S_HOLD: begin
                    // Soft reset held high keeps restarting the interval.
                    if (soft_reset)               hold_cnt_d = HOLD_LOAD;
                    else if (hold_cnt_q == '0)    state_d    = S_RUN;
                    else                          hold_cnt_d = hold_cnt_q - 1'b1;
                end
                S_RUN: begin
                    if (sr_rise) begin
                        state_d    = S_HOLD;
                        hold_cnt_d = HOLD_LOAD;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            hold_cnt_q   <= '0;
            exp_addr_q   <= '0;
            byte_count_q <= '0;
            err_q        <= 1'b0;
            rom_valid_q  <= 1'b0;
            load_error_q <= 1'b0;
            dn_addr_q    <= '0;
            dn_data_q    <= '0;
            dn_wr_q      <= 1'b0;
            dl_q         <= 1'b0;
            sr_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            exp_addr_q   <= exp_addr_d;
            byte_count_q <= byte_count_d;
            err_q        <= err_d;
            rom_valid_q  <= rom_valid_d;
            load_error_q <= load_error_d;
            dn_addr_q    <= dn_addr_d;
            dn_data_q    <= dn_data_d;
            dn_wr_q      <= dn_wr_d;
            dl_q         <= ioctl_download;
            sr_q         <= soft_reset;
        end
    end

    // Decoded straight from the state flop so async reset asserts it at once.
    assign core_reset = (state_q != S_RUN);
    assign dn_addr    = dn_addr_q;
    assign dn_data    = dn_data_q;
    assign dn_wr      = dn_wr_q;
    assign rom_valid  = rom_valid_q;
    assign load_error = load_error_q;
    assign byte_count = byte_count_q;

endmodule

// File: doc/rom_load_sequencer.md
# rom_load_sequencer

Sequences the HPS ROM download into the arcade core and owns the core's reset. It registers the `ioctl_*` write stream onto the core's `dn_*` port, checks the image for sequential addressing and exact size, and holds the core in reset until a valid image is loaded. After every load or soft reset it keeps the core in reset for a programmable interval before releasing it. It sits between `hps_io` and the `ladybug` core in `emu`, replacing the ad-hoc OR of reset sources.

## Interface
- `TOTAL_BYTES`, default 49152: exact image size required for a valid load.
- `HOLD_CYCLES`, default 1024: core-reset hold length after a good load or a soft reset (≥1).
- `clk_sys`  in  1  system clock; all logic is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ioctl_download`  in  1  download window from `hps_io`.
- `ioctl_wr`  in  1  single-cycle write strobe.
- `ioctl_addr`  in  25  byte address of the write.
- `ioctl_dout`  in  8  byte data of the write.
- `soft_reset`  in  1  level request, e.g. `status[0] | buttons[1]`.
- `dn_addr`  out  16  registered write address to the core.
- `dn_data`  out  8  registered write data to the core.
- `dn_wr`  out  1  registered write strobe to the core.
- `core_reset`  out  1  active-high reset to the core.
- `rom_valid`  out  1  last completed load was good.
- `load_error`  out  1  last completed load failed; sticky until the next download starts.
- `byte_count`  out  17  writes accepted in the current or last load.

## Operation
- **States:** IDLE, LOAD, CHECK, HOLD, RUN.
- **Reset values:** state IDLE, `core_reset` 1, all other outputs 0, hold counter 0, expected-address counter 0.
- **Download start:** rising edge of `ioctl_download` (registered copy 0, input 1) moves any state to LOAD. On that entry, clear `byte_count`, expected address, `rom_valid` and `load_error`.
- **LOAD acceptance:** a write (`ioctl_wr`=1) is accepted when `ioctl_addr` < `TOTAL_BYTES` and `ioctl_addr` == expected address.
  - Accepted write: the next cycle shows `dn_addr`=`ioctl_addr[15:0]`, `dn_data`=`ioctl_dout` and `dn_wr`=1; `byte_count` and expected address increment.
  - Rejected write: produces no `dn_wr` and sets an internal error flag, which stays set until LOAD is re-entered.
- **Writes outside LOAD**, or with `ioctl_download`=0, are ignored: no `dn_wr`, no error.
- **`dn_wr`** is high for exactly one cycle per accepted write. `dn_addr`/`dn_data` hold their last value otherwise.
- **CHECK:** entered on the falling edge of `ioctl_download` in LOAD, and lasts one cycle.
  - Pass (`byte_count` == `TOTAL_BYTES` and error flag clear): `rom_valid`←1, go to HOLD.
  - Fail: `load_error`←1, go to IDLE.
- **HOLD:** hold counter loads `HOLD_CYCLES-1` on entry and decrements each cycle. At 0 the state moves to RUN.
- **RUN:** a rising edge of `soft_reset` moves to HOLD, reloading the counter.
- **`soft_reset` in HOLD:** a level held high keeps the counter reloaded, so release happens `HOLD_CYCLES` cycles after `soft_reset` falls.
- **`soft_reset` in IDLE, LOAD or CHECK:** no effect.
- **`core_reset`** is 1 in every state except RUN.
- **Counter widths:** `byte_count` and expected address saturate at 2^17−1 and never wrap. The hold counter is `$clog2(HOLD_CYCLES)` bits (minimum 1).
- **Download edge priority:** a new download rising edge has priority over every other transition, including CHECK and HOLD.

## Timing
- Write latency: `ioctl_wr` at cycle n produces `dn_wr` at n+1. Throughput is one write per cycle.
- Download end: `ioctl_download` falls at cycle n; the registered edge puts CHECK at n+1 and HOLD or IDLE at n+2.
- A write sampled in the same cycle that `ioctl_download` falls is ignored.
- Release after a good load: `core_reset` deasserts exactly `HOLD_CYCLES` cycles after HOLD entry.
- Asynchronous `reset_n` assertion mid-load forces IDLE immediately, with `core_reset`=1 and `rom_valid`=0. A partial load is never marked valid.

## Test plan
- **Good load:** `TOTAL_BYTES`=16, `HOLD_CYCLES`=4; download with 16 sequential writes, then drop `ioctl_download`.
  - Required: 16 `dn_wr` pulses, each one cycle after its `ioctl_wr`, with matching address/data; `byte_count`=16; `rom_valid`=1; `core_reset` falls 4 cycles after HOLD entry.
- **Short load:** 15 writes, then drop the download.
  - Required: `load_error`=1, `rom_valid`=0, `core_reset` stays 1, state IDLE.
- **Address gap:** writes to 0,1,3,…
  - Required: no `dn_wr` for address 3; at CHECK `load_error`=1.
- **Out-of-range write:** a write to address 16 after a full image.
  - Required: dropped, `load_error`=1.
- **Soft reset:** in RUN, pulse `soft_reset` for 3 cycles.
  - Required: `core_reset` high from the next cycle until 4 cycles after `soft_reset` falls; `rom_valid` stays 1.
- **Reset and reload:** assert `reset_n`=0 mid-load.
  - Required: all outputs return to reset values immediately.
  - Then restart the download during HOLD of a good load: state goes to LOAD, `rom_valid` clears the next cycle, `core_reset` stays 1.
